// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, 3-sample majority per bit, early stop return,
// framing-error/break handling and an idle-gap timeout strobe after each good byte.
module uart_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned IDLE_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       idle_tout,
    output logic       busy
);

    localparam int unsigned MID    = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned TOUT   = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned TOUT_W = $clog2(TOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_S0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0]  CNT_S1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0]  CNT_DEC   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state;
    logic                rxd_m;
    logic                rxd_s;
    logic                samp0;
    logic                samp1;
    logic                maj;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                tout_armed;
    logic [TOUT_W-1:0]   tout_cnt;

    // Metastability guard; idle-high reset value so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // First two of the three mid-bit samples; the third is rxd_s at the decision point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0 <= 1'b1;
            samp1 <= 1'b1;
        end else if (state == S_START || state == S_DATA || state == S_STOP) begin
            if (cnt == CNT_S0) samp0 <= rxd_s;
            if (cnt == CNT_S1) samp1 <= rxd_s;
        end
    end

    assign maj = (samp0 & samp1) | (samp0 & rxd_s) | (samp1 & rxd_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            idle_tout  <= 1'b0;
            busy       <= 1'b0;
            tout_armed <= 1'b0;
            tout_cnt   <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            idle_tout <= 1'b0;

            // Idle-gap timer: only counts IDLE cycles while armed by a good byte
            if (tout_armed) begin
                if (state == S_IDLE) begin
                    if (tout_cnt == TOUT_LAST) begin
                        idle_tout  <= 1'b1;
                        tout_armed <= 1'b0;
                        tout_cnt   <= '0;
                    end else begin
                        tout_cnt <= tout_cnt + TOUT_W'(1);
                    end
                end else begin
                    tout_cnt <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == CNT_DEC && maj) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_DEC) shreg <= {maj, shreg[7:1]};
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) state   <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Decide mid-stop and return early so a fast sender's next start is not missed
                    if (cnt == CNT_DEC) begin
                        tout_cnt <= '0;
                        if (maj) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            tout_armed <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                            state      <= S_BREAK;
                            tout_armed <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx (CLKS_PER_BIT=16, IDLE_BITS=4): vector table,
// hand-written corner sequences and a randomized byte stream against a byte-level model.
module tb_uart_byte_rx;

    localparam int CPB       = 16;
    localparam int IDLE_BITS = 4;
    localparam int LAT_MIN   = 155;
    localparam int LAT_MAX   = 157;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       idle_tout;
    logic       busy;

    uart_byte_rx #(
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (IDLE_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .idle_tout(idle_tout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rx_ev_t;

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    rx_ev_t val_q[$];
    int     ferr_q[$];
    int     tout_q[$];
    int     total = 0;
    int     bad = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        val_q.delete();
        ferr_q.delete();
        tout_q.delete();
    endtask

    // Sender: start, 8 data bits LSB first, optional low stop for stop_low cycles, then a high stop bit
    task automatic send_byte(input logic [7:0] d, input int stop_low, output int fall);
        rxd  = 1'b0;
        fall = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            tick(stop_low);
        end
        rxd = 1'b1;
        tick(CPB);
    endtask

    function automatic int lat_ok(input int lat);
        return (lat >= LAT_MIN && lat <= LAT_MAX) ? 1 : 0;
    endfunction

    // Event monitor; strobes must never overlap
    always @(negedge clk) begin
        if (rx_valid)  val_q.push_back('{cyc, rx_data});
        if (frame_err) ferr_q.push_back(cyc);
        if (idle_tout) tout_q.push_back(cyc);
        if (rx_valid || frame_err || idle_tout)
            check("strobe_excl", int'(rx_valid) + int'(frame_err) + int'(idle_tout), 1);
    end

    initial begin
        vec_t        vecs[6];
        logic [7:0]  frame[10];
        logic [7:0]  exp_bytes[$];
        int          exp_falls[$];
        int          falls[10];
        int          fall;
        int          rx_cyc;
        int          exp_ferr;
        int          last_good;
        logic [7:0]  d;
        logic [7:0]  b3c;
        int          good;

        vecs[0] = '{8'hEB, 0,   1, 0, 8'hEB};
        vecs[1] = '{8'h00, 0,   1, 0, 8'h00};
        vecs[2] = '{8'hFF, 0,   1, 0, 8'hFF};
        vecs[3] = '{8'h81, 0,   1, 0, 8'h81};
        vecs[4] = '{8'h55, CPB, 0, 1, 8'h81};
        vecs[5] = '{8'hA5, 0,   1, 0, 8'hA5};
        frame   = '{8'hEB, 8'h9C, 8'h02, 8'h00, 8'h20, 8'h00, 8'h10, 8'h00, 8'h00, 8'h05};

        // Reset state
        tick(3);
        check("rst_rx_data",   int'(rx_data),   0);
        check("rst_rx_valid",  int'(rx_valid),  0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_idle_tout", int'(idle_tout), 0);
        check("rst_busy",      int'(busy),      0);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_busy", int'(busy), 0);

        // Vector table: one byte per entry
        for (int i = 0; i < 6; i++) begin
            clear_q();
            send_byte(vecs[i].data, vecs[i].stop_low, fall);
            tick(40);
            check($sformatf("vec%0d_valid_cnt", i), val_q.size(), vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_cnt", i), ferr_q.size(), vecs[i].exp_ferr);
            check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            if (vecs[i].exp_valid == 1)
                check($sformatf("vec%0d_latency", i), lat_ok(val_q.size() > 0 ? val_q[0].cyc - fall : -1), 1);
        end

        // Full frame back-to-back
        tick(100);
        clear_q();
        for (int i = 0; i < 10; i++) send_byte(frame[i], 0, falls[i]);
        tick(20);
        check("frame_cnt", val_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("frame_byte%0d", i), int'(val_q[i].data), int'(frame[i]));
            if (i > 0) check($sformatf("frame_gap%0d", i), val_q[i].cyc - val_q[i-1].cyc, 160);
        end
        check("frame_ferr", ferr_q.size(), 0);
        check("frame_busy_end", int'(busy), 0);

        // Bad stop held low three bit times: FSM must sit in BREAK until line returns high
        tick(100);
        clear_q();
        d   = 8'h55;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = 1'b0;
        tick(40);
        check("brk_ferr", ferr_q.size(), 1);
        check("brk_busy_held", int'(busy), 1);
        tick(8);
        rxd = 1'b1;
        tick(10);
        check("brk_busy_released", int'(busy), 0);
        check("brk_no_valid", val_q.size(), 0);
        check("brk_ferr_once", ferr_q.size(), 1);
        send_byte(8'hA5, 0, fall);
        tick(20);
        check("brk_next_cnt", val_q.size(), 1);
        check("brk_next_data", int'(val_q[0].data), 'hA5);

        // False start: 4-cycle low pulse on idle line
        tick(100);
        clear_q();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(2);
        check("fs_busy_seen", int'(busy), 1);
        tick(8);
        check("fs_busy_low", int'(busy), 0);
        tick(30);
        check("fs_no_valid", val_q.size(), 0);
        check("fs_no_ferr", ferr_q.size(), 0);

        // 1-cycle high glitch at the centre of data bit 3 of 0x00
        clear_q();
        rxd = 1'b0;
        tick(CPB * 4);
        tick(CPB / 2);
        rxd = 1'b1;
        tick(1);
        rxd = 1'b0;
        tick(CPB / 2 - 1);
        tick(CPB * 4);
        rxd = 1'b1;
        tick(CPB + 20);
        check("gl_cnt", val_q.size(), 1);
        check("gl_data", int'(val_q[0].data), 0);
        check("gl_ferr", ferr_q.size(), 0);

        // Idle timeout: single pulse 64 cycles after rx_valid, never repeated
        tick(200);
        clear_q();
        send_byte(8'h12, 0, fall);
        tick(100);
        check("to_valid", val_q.size(), 1);
        check("to_cnt", tout_q.size(), 1);
        check("to_delay", tout_q[0] - val_q[0].cyc, IDLE_BITS * CPB);
        tick(300);
        check("to_no_repeat", tout_q.size(), 1);

        // Second byte 40 idle cycles later suppresses and re-arms the timer
        clear_q();
        send_byte(8'h34, 0, fall);
        rx_cyc = val_q[0].cyc;
        tick(rx_cyc + 40 - cyc);
        send_byte(8'h56, 0, fall);
        tick(100);
        check("to2_valid", val_q.size(), 2);
        check("to2_cnt", tout_q.size(), 1);
        check("to2_delay", tout_q[0] - val_q[1].cyc, IDLE_BITS * CPB);

        // Reset during data bit 4 of 0x3C
        clear_q();
        b3c = 8'h3C;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b3c[i];
            tick(CPB);
        end
        rxd = b3c[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(2);
        check("mr_rx_data",   int'(rx_data),   0);
        check("mr_rx_valid",  int'(rx_valid),  0);
        check("mr_frame_err", int'(frame_err), 0);
        check("mr_idle_tout", int'(idle_tout), 0);
        check("mr_busy",      int'(busy),      0);
        rxd   = 1'b1;
        rst_n = 1'b1;
        tick(200);
        check("mr_no_valid", val_q.size(), 0);
        check("mr_no_ferr", ferr_q.size(), 0);
        check("mr_no_tout", tout_q.size(), 0);
        send_byte(8'hC3, 0, fall);
        tick(20);
        check("mr_next_cnt", val_q.size(), 1);
        check("mr_next_data", int'(val_q[0].data), 'hC3);

        // Randomized stream against a byte-level model
        tick(200);
        clear_q();
        exp_ferr  = 0;
        last_good = 0;
        for (int i = 0; i < 30; i++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0) ? 1 : 0;
            send_byte(d, (good == 1) ? 0 : CPB, fall);
            if (good == 1) begin
                exp_bytes.push_back(d);
                exp_falls.push_back(fall);
            end else begin
                exp_ferr++;
            end
            last_good = good;
            tick($urandom_range(0, 20));
        end
        tick(150);
        check("rnd_valid_cnt", val_q.size(), exp_bytes.size());
        check("rnd_ferr_cnt", ferr_q.size(), exp_ferr);
        check("rnd_tout_cnt", tout_q.size(), last_good);
        for (int i = 0; i < exp_bytes.size(); i++) begin
            check($sformatf("rnd_byte%0d", i), int'(val_q[i].data), int'(exp_bytes[i]));
            check($sformatf("rnd_lat%0d", i), lat_ok(val_q[i].cyc - exp_falls[i]), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
